// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_pkg
// Purpose  : Shared constants and result type for the ripple-carry full adder.
// Revision : 1.0 - initial release
// ============================================================================
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  typedef struct packed {
    logic                    carry;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;

endpackage : full_adder_pkg
`default_nettype wire

// File: rtl/full_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_if
// Purpose  : Operand/result bundle for full_adder; ovf/ovf_q exist only when
//            FULL_ADDER_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface full_adder_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;
  logic             ovf_q;
`endif

  modport master (
    output a, b, cin, in_valid,
    input  sum, carry, sum_q, carry_q, out_valid
`ifdef FULL_ADDER_OVF_EN
    , input ovf, ovf_q
`endif
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, carry, sum_q, carry_q, out_valid
`ifdef FULL_ADDER_OVF_EN
    , output ovf, ovf_q
`endif
  );

endinterface : full_adder_if
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module   : half_adder
// Purpose  : Single-bit half adder cell (s = x ^ y, c = x & y).
// Revision : 1.0 - initial release
// ============================================================================
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule : half_adder
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : Ripple-carry adder of half-adder pairs with a registered, valid-
//            qualified copy. FULL_ADDER_OVF_EN adds signed overflow outputs.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  full_adder_if.slave  bus
);

  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH:0]   chain;

  assign chain[0] = bus.cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      half_adder u_ha_in (
        .x (bus.a[i]),
        .y (bus.b[i]),
        .s (prop[i]),
        .c (gen[i])
      );
      half_adder u_ha_carry (
        .x (prop[i]),
        .y (chain[i]),
        .s (sum_comb[i]),
        .c (term[i])
      );
      assign chain[i+1] = gen[i] | term[i];
    end : g_bit
  endgenerate

  assign bus.sum   = sum_comb;
  assign bus.carry = chain[WIDTH];

  logic [WIDTH-1:0] sum_hold_d,   sum_hold_q;
  logic             carry_hold_d, carry_hold_q;
  logic             valid_d,      valid_q;

  always_comb begin
    valid_d      = bus.in_valid;
    sum_hold_d   = bus.in_valid ? sum_comb     : sum_hold_q;
    carry_hold_d = bus.in_valid ? chain[WIDTH] : carry_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_hold_q   <= '0;
      carry_hold_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      sum_hold_q   <= sum_hold_d;
      carry_hold_q <= carry_hold_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.sum_q     = sum_hold_q;
  assign bus.carry_q   = carry_hold_q;
  assign bus.out_valid = valid_q;

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  logic ovf_comb;
  logic ovf_hold_d, ovf_hold_q;

  assign ovf_comb = chain[WIDTH] ^ chain[WIDTH-1];

  always_comb begin
    ovf_hold_d = bus.in_valid ? ovf_comb : ovf_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_hold_q <= 1'b0;
    end else begin
      ovf_hold_q <= ovf_hold_d;
    end
  end

  assign bus.ovf   = ovf_comb;
  assign bus.ovf_q = ovf_hold_q;
`endif

endmodule : full_adder
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_adder
// Purpose  : Self-checking bench for full_adder at WIDTH=1 and WIDTH=8
//            (FULL_ADDER_OVF_EN adds overflow checks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();

  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum and signed-range overflow test.
  function automatic fa_result_t ref_add(input int unsigned av, input int unsigned bv,
                                         input int unsigned cv, input int w);
    fa_result_t  r;
    longint unsigned total;
    total   = longint'(av) + longint'(bv) + longint'(cv);
    r.sum   = 64'(total % (64'd1 << w));
    r.carry = (total >> w) != 0;
    return r;
  endfunction

  function automatic logic ref_ovf8(input int unsigned av, input int unsigned bv,
                                    input int unsigned cv);
    int sa, sb, st;
    sa = (av >= 128) ? int'(av) - 256 : int'(av);
    sb = (bv >= 128) ? int'(bv) - 256 : int'(bv);
    st = sa + sb + int'(cv);
    return (st > 127) || (st < -128);
  endfunction

  fa_result_t  exp_r;
  logic [7:0]  m_sum_q;
  logic        m_carry_q;
  logic        m_valid;
  logic        m_ovf_q;
  logic        m_ovf;
  int unsigned ra, rb, rc, rv;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_sum_q = '0; m_carry_q = 1'b0; m_valid = 1'b0; m_ovf_q = 1'b0; m_ovf = 1'b0;

    // Reset held with all-ones operands on the 1-bit adder
    rst_n = 1'b0;
    if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.in_valid = 1'b1;
    if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0; if8.in_valid = 1'b0;
    #12;
    check("rst_sum_q",     65'(if1.sum_q),     65'd0);
    check("rst_carry_q",   65'(if1.carry_q),   65'd0);
    check("rst_out_valid", 65'(if1.out_valid), 65'd0);
    check("rst_sum_comb",  65'(if1.sum),       65'd1);
    check("rst_carry_comb",65'(if1.carry),     65'd1);
    check("rst8_sum_q",    65'(if8.sum_q),     65'd0);
    check("rst8_valid",    65'(if8.out_valid), 65'd0);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("rel_sum_q",     65'(if1.sum_q),     65'd1);
    check("rel_carry_q",   65'(if1.carry_q),   65'd1);
    check("rel_out_valid", 65'(if1.out_valid), 65'd1);

    // WIDTH=1 exhaustive, combinational outputs
    if1.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if1.a   = k[2];
      if1.b   = k[1];
      if1.cin = k[0];
      #10;
      exp_r = ref_add(int'(k[2]), int'(k[1]), int'(k[0]), 1);
      check($sformatf("w1_sum_%0d", k),   65'(if1.sum),   65'(exp_r.sum));
      check($sformatf("w1_carry_%0d", k), 65'(if1.carry), 65'(exp_r.carry));
    end

    // Capture then hold with in_valid low
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b0; if1.cin = 1'b0; if1.in_valid = 1'b1;
    @(posedge clk) #1;
    check("cap_sum_q",   65'(if1.sum_q),     65'd1);
    check("cap_valid",   65'(if1.out_valid), 65'd1);
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b0; if1.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk) #1;
      check("hold_sum_q",   65'(if1.sum_q),     65'd1);
      check("hold_carry_q", 65'(if1.carry_q),   65'd0);
      check("hold_valid",   65'(if1.out_valid), 65'd0);
    end

    // WIDTH=8 boundaries (in_valid low, registered copy untouched)
    if8.a = 8'hFF; if8.b = 8'h00; if8.cin = 1'b1; #1;
    check("w8_wrap_sum",   65'(if8.sum),   65'h00);
    check("w8_wrap_carry", 65'(if8.carry), 65'd1);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; #1;
    check("w8_ones_sum",   65'(if8.sum),   65'hFF);
    check("w8_ones_carry", 65'(if8.carry), 65'd1);
    if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0; #1;
    check("w8_zero_sum",   65'(if8.sum),   65'h00);
    check("w8_zero_carry", 65'(if8.carry), 65'd0);
`ifdef FULL_ADDER_OVF_EN
    if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0; #1;
    check("ovf_pos_sum",   65'(if8.sum),   65'h80);
    check("ovf_pos_carry", 65'(if8.carry), 65'd0);
    check("ovf_pos_ovf",   65'(if8.ovf),   65'd1);
    if8.a = 8'hFF; if8.b = 8'h01; if8.cin = 1'b0; #1;
    check("ovf_neg_sum",   65'(if8.sum),   65'h00);
    check("ovf_neg_carry", 65'(if8.carry), 65'd1);
    check("ovf_neg_ovf",   65'(if8.ovf),   65'd0);
    if1.a = 1'b1; if1.b = 1'b0; if1.cin = 1'b1; #1;
    check("ovf_w1",        65'(if1.ovf),   65'd0);
`endif

    // Randomized WIDTH=8 traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      rc = $urandom_range(0, 1);
      rv = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if8.a = 8'(ra); if8.b = 8'(rb); if8.cin = rc[0]; if8.in_valid = rv[0];
      #1;
      exp_r = ref_add(ra, rb, rc, 8);
      m_ovf = ref_ovf8(ra, rb, rc);
      check("rnd_sum",   65'(if8.sum),   65'(exp_r.sum));
      check("rnd_carry", 65'(if8.carry), 65'(exp_r.carry));
`ifdef FULL_ADDER_OVF_EN
      check("rnd_ovf",   65'(if8.ovf),   65'(m_ovf));
`endif
      @(posedge clk) #1;
      m_valid = rv[0];
      if (rv[0]) begin
        m_sum_q   = exp_r.sum[7:0];
        m_carry_q = exp_r.carry;
        m_ovf_q   = m_ovf;
      end
      check("rnd_sum_q",   65'(if8.sum_q),     65'(m_sum_q));
      check("rnd_carry_q", 65'(if8.carry_q),   65'(m_carry_q));
      check("rnd_valid",   65'(if8.out_valid), 65'(m_valid));
`ifdef FULL_ADDER_OVF_EN
      check("rnd_ovf_q",   65'(if8.ovf_q),     65'(m_ovf_q));
`endif
    end

    // Asynchronous reset between edges while out_valid is high
    @(negedge clk);
    if8.a = 8'h03; if8.b = 8'h04; if8.cin = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk) #1;
    check("pre_arst_valid", 65'(if8.out_valid), 65'd1);
    check("pre_arst_sum_q", 65'(if8.sum_q),     65'h07);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum_q",   65'(if8.sum_q),     65'd0);
    check("arst_carry_q", 65'(if8.carry_q),   65'd0);
    check("arst_valid",   65'(if8.out_valid), 65'd0);
    check("arst_sum",     65'(if8.sum),       65'h07);
`ifdef FULL_ADDER_OVF_EN
    check("arst_ovf_q",   65'(if8.ovf_q),     65'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("post_arst_sum_q", 65'(if8.sum_q),     65'h07);
    check("post_arst_valid", 65'(if8.out_valid), 65'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_full_adder
`default_nettype wire

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterised ripple-carry adder built from half-adder cells. Each bit is a full adder made of two half adders plus an OR for carry.
- Produces combinational sum/carry outputs for the datapath, plus a registered copy with a valid flag for pipelined consumers.
- With WIDTH=1 it is the classic 1-bit full adder (a, b, cin -> sum, carry).

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  clock; all registers update on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- cin  input  1  carry-in to bit 0.
- in_valid  input  1  qualifies a/b/cin for the registered stage.
- sum  output  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH.
- carry  output  1  combinational carry-out of MSB.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  1  registered carry.
- out_valid  output  1  registered in_valid.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Per bit i, with c0 = cin:
  - Half adder 1: p_i = a_i XOR b_i, g_i = a_i AND b_i.
  - Half adder 2: sum_i = p_i XOR c_i, t_i = p_i AND c_i.
  - Carry chain: c_{i+1} = g_i OR t_i.
  - carry = c_WIDTH.
- {carry, sum} equals a + b + cin exactly, computed at WIDTH+1 bits; no truncation of carry.
- sum and carry are purely combinational:
  - Zero-cycle latency; valid after propagation delay.
  - Independent of clk, rst_n and in_valid; they follow the inputs even during reset.
- Registered stage, 1-cycle latency:
  - On each rising clk, out_valid <= in_valid.
  - When in_valid=1: sum_q <= sum, carry_q <= carry.
  - When in_valid=0: sum_q and carry_q hold their previous value.
- Reset: while rst_n=0, sum_q=0, carry_q=0 and out_valid=0, asserted immediately without waiting for clk.
- Reset deassertion is synchronised externally. The first capture occurs on the first rising clk with rst_n=1.
- Reset asserted mid-operation clears the registered outputs at once; combinational outputs are unaffected.
- Boundary conditions:
  - All-ones + all-ones + cin=1 gives sum = all-ones, carry=1.
  - All-zeros with cin=0 gives sum=0, carry=0.
- No X propagation from the registered stage after reset; the inputs are assumed known when in_valid=1.

Optional Feature:
- Macro FULL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, combinational) = c_WIDTH XOR c_{WIDTH-1}, i.e. signed two's-complement overflow.
  - Adds ovf_q, registered under the same in_valid/reset rules (reset value 0).
  - For WIDTH=1, c_0 = cin.
- Undefined: ports ovf and ovf_q do not exist; all other behaviour is identical.

Decomposition:
- Package full_adder_pkg holds:
  - Constant FA_DEFAULT_WIDTH = 1.
  - Constant FA_MAX_WIDTH = 64.
  - Typedef fa_result_t, a packed struct {carry, sum} for bench/reference-model use.
- Sub-module half_adder (inputs x, y; outputs s = x XOR y, c = x AND y), instantiated twice per bit via generate loop.
- The carry OR and the registers live in full_adder.

Test Plan:
- WIDTH=1 exhaustive: all 8 combinations of a,b,cin, 10 ns apart, checked on combinational outputs.
  - 000 -> sum=0,carry=0
  - 001, 010, 100 -> sum=1,carry=0
  - 011, 101, 110 -> sum=0,carry=1
  - 111 -> sum=1,carry=1
- Reset: rst_n=0 with a=1,b=1,cin=1,in_valid=1 -> sum_q=0,carry_q=0,out_valid=0, while sum=1,carry=1.
  - Release reset -> after one clk edge sum_q=1,carry_q=1,out_valid=1.
- Hold: capture a=1,b=0,cin=0 with in_valid=1, then drive a=1,b=1,cin=0 with in_valid=0 for 3 cycles -> sum_q stays 1, carry_q stays 0, out_valid=0.
- WIDTH=8 wrap: a=0xFF,b=0x00,cin=1 -> sum=0x00,carry=1; a=0xFF,b=0xFF,cin=1 -> sum=0xFF,carry=1.
- Async reset mid-stream: assert rst_n=0 between clk edges while out_valid=1 -> registered outputs clear before the next edge.
- FULL_ADDER_OVF_EN, WIDTH=8:
  - a=0x7F,b=0x01,cin=0 -> sum=0x80,carry=0,ovf=1.
  - a=0xFF,b=0x01,cin=0 -> sum=0x00,carry=1,ovf=0.
